// File: rtl/axi_rd_burst_ctrl.sv
// axi_rd_burst_ctrl
// Splits one read request (start address + word count) into AXI4 INCR bursts
// of at most MAX_BURST beats that never cross a 4 KB boundary, issues them one
// at a time to the read engine, ORs the per-burst engine errors and pulses
// done when the whole transfer has finished.
module axi_rd_burst_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = 8,
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [CNT_W-1:0]     req_nwords,
  output logic                 req_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 run,
  output logic [ADDR_W-1:0]    addr,
  output logic [AXI_LEN_W-1:0] length,
  input  logic                 eng_ready,
  input  logic                 eng_error
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int BEAT_W = AXI_LEN_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]       remaining_q, remaining_d;
  logic [BEAT_W-1:0]      beats_q, beats_d;
  logic                   err_acc_q, err_acc_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic                   run_q, run_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [AXI_LEN_W-1:0]   length_q, length_d;

  logic [12:0]            to4k;
  logic [BEAT_W-1:0]      cap;
  logic [BEAT_W-1:0]      burst_beats;

  // Size of the next burst: smallest of words left, MAX_BURST and words to the 4 KB line
  always_comb begin
    to4k        = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> OFF_W;
    cap         = BEAT_W'(MAX_BURST);
    burst_beats = '0;
    if (32'(to4k) < 32'(MAX_BURST)) begin
      cap = BEAT_W'(to4k);
    end
    if (32'(remaining_q) < 32'(cap)) begin
      burst_beats = BEAT_W'(remaining_q);
    end else begin
      burst_beats = cap;
    end
  end

  // Sequencer next-state and datapath updates; run/done follow the next state so they are registered
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    err_acc_d   = err_acc_q;
    err_d       = err_q;
    addr_d      = addr_q;
    length_d    = length_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cur_addr_d  = req_addr & ALIGN_MASK;
          remaining_d = req_nwords;
          err_acc_d   = 1'b0;
          err_d       = 1'b0;
          state_d     = (req_nwords == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        beats_d  = burst_beats;
        addr_d   = cur_addr_q;
        length_d = AXI_LEN_W'(burst_beats - BEAT_W'(1));
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (!eng_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (eng_ready) begin
          err_acc_d   = err_acc_q | eng_error;
          cur_addr_d  = cur_addr_q + (ADDR_W'(beats_q) << OFF_W);
          remaining_d = remaining_q - CNT_W'(beats_q);
          if (remaining_d == '0) begin
            state_d = DONE;
            err_d   = err_acc_d;
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    run_d  = (state_d == ISSUE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      err_acc_q   <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
      addr_q      <= '0;
      length_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      err_acc_q   <= err_acc_d;
      err_q       <= err_d;
      done_q      <= done_d;
      run_q       <= run_d;
      addr_q      <= addr_d;
      length_q    <= length_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign run       = run_q;
  assign addr      = addr_q;
  assign length    = length_q;

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
// tb_axi_rd_burst_ctrl
// Directed bench for axi_rd_burst_ctrl: a simple engine responder, a
// burst-list model computed from the address/count rules, a monitor that
// checks every issued burst and done pulse, and literal expectations.
module tb_axi_rd_burst_ctrl;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int AXI_LEN_W = 8;
  localparam int MAX_BURST = 256;
  localparam int CNT_W     = 16;
  localparam int BYTES     = DATA_W / 8;

  typedef struct {
    logic [ADDR_W-1:0]    adr;
    logic [AXI_LEN_W-1:0] len;
  } burst_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid;
  logic [ADDR_W-1:0]    req_addr;
  logic [CNT_W-1:0]     req_nwords;
  logic                 req_ready;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 run;
  logic [ADDR_W-1:0]    addr;
  logic [AXI_LEN_W-1:0] length;
  logic                 eng_ready;
  logic                 eng_error;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;

  burst_t            expQ[$];
  logic              expErr;
  bit                inXfer = 1'b0;
  burst_t            curExp;
  bit                prevRun = 1'b0;
  logic [ADDR_W-1:0] logAddr[$];
  int                logLen[$];
  int                runCycle[$];
  int                doneCount = 0;
  int                doneCycle = -1;
  int                accCycle  = 0;
  logic [31:0]       errMask = '0;
  int                engLat  = 1;
  int                engBurst = 0;

  axi_rd_burst_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_LEN_W(AXI_LEN_W),
    .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_nwords(req_nwords), .req_ready(req_ready), .busy(busy), .done(done),
    .err(err), .run(run), .addr(addr), .length(length),
    .eng_ready(eng_ready), .eng_error(eng_error)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp observed events
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine responder: accepts a burst when run meets ready, stays busy engLat cycles, then reports
  initial begin
    bit rstS;
    bit hs;
    int cnt;
    bit curErr;
    eng_ready = 1'b1;
    eng_error = 1'b0;
    cnt       = 0;
    curErr    = 1'b0;
    forever begin
      @(negedge clk);
      rstS = (rst === 1'b1);
      hs   = (run === 1'b1) && (eng_ready === 1'b1);
      @(posedge clk);
      #1;
      if (rstS) begin
        eng_ready = 1'b1;
        eng_error = 1'b0;
        cnt       = 0;
      end else if (hs) begin
        eng_ready = 1'b0;
        eng_error = 1'b0;
        cnt       = engLat;
        curErr    = (engBurst < 32) ? errMask[engBurst] : 1'b0;
        engBurst++;
      end else if (!eng_ready) begin
        if (cnt <= 1) begin
          eng_ready = 1'b1;
          eng_error = curErr;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: every issued burst and done pulse is checked against the model
  initial begin
    forever begin
      @(negedge clk);
      if (run === 1'b1) begin
        if (!prevRun) begin
          logAddr.push_back(addr);
          logLen.push_back(int'(length));
          runCycle.push_back(cycle);
          if (expQ.size() == 0) begin
            checkOutput("unexpected_burst", 1, 0);
          end else begin
            curExp = expQ.pop_front();
            checkOutput("burst_addr", addr, curExp.adr);
            checkOutput("burst_len", length, curExp.len);
          end
        end else begin
          checkOutput("addr_hold", addr, curExp.adr);
          checkOutput("len_hold", length, curExp.len);
        end
      end
      prevRun = (run === 1'b1);
      if (done === 1'b1) begin
        doneCount++;
        doneCycle = cycle;
        if (!inXfer) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          checkOutput("err_at_done", err, expErr);
          checkOutput("bursts_left_at_done", expQ.size(), 0);
          inXfer = 1'b0;
        end
      end
    end
  end

  // Issue one request, build the expected burst list, optionally wait for done
  task automatic applyStimulus(input logic [ADDR_W-1:0] aIn, input int nw,
                               input logic [31:0] mask, input int lat, input bit waitDone);
    int g;
    int k;
    logic [ADDR_W-1:0] ca;
    longint rem;
    longint room;
    longint b;
    g = 0;
    while (req_ready !== 1'b1 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("req_ready_before_req", req_ready, 1);
    errMask    = mask;
    engLat     = lat;
    engBurst   = 0;
    req_valid  = 1'b1;
    req_addr   = aIn;
    req_nwords = CNT_W'(nw);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = ~aIn;
    req_nwords = '1;
    accCycle   = cycle;
    ca     = aIn & ~ADDR_W'(BYTES - 1);
    rem    = longint'(nw);
    expErr = 1'b0;
    k      = 0;
    while (rem > 0) begin
      room = (4096 - longint'(ca[11:0])) / BYTES;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      expQ.push_back('{adr: ca, len: AXI_LEN_W'(b - 1)});
      if (k < 32 && mask[k]) expErr = 1'b1;
      k++;
      ca  = ca + ADDR_W'(b * BYTES);
      rem = rem - b;
    end
    inXfer = 1'b1;
    checkOutput("err_cleared_on_accept", err, 0);
    checkOutput("busy_after_accept", busy, 1);
    if (waitDone) begin
      g = 0;
      while (inXfer && g < 5000) begin
        @(negedge clk);
        g++;
      end
      if (inXfer) begin
        checkOutput("done_timeout", 0, 1);
        inXfer = 1'b0;
        expQ.delete();
      end
    end
  endtask

  // Directed test sequence
  initial begin
    int base;
    int d0;
    int g;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_nwords = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_run", run, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_length", length, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single short burst
    base = logAddr.size(); d0 = doneCount;
    applyStimulus(32'h000, 16, 32'h0, 1, 1'b1);
    checkOutput("t1_nbursts", logAddr.size() - base, 1);
    checkOutput("t1_addr", logAddr[base], 32'h000);
    checkOutput("t1_len", logLen[base], 15);
    checkOutput("t1_run_latency", runCycle[base] - accCycle, 1);
    checkOutput("t1_done_count", doneCount - d0, 1);
    checkOutput("t1_err", err, 0);

    // Three bursts limited by MAX_BURST
    base = logAddr.size(); d0 = doneCount;
    applyStimulus(32'h000, 600, 32'h0, 3, 1'b1);
    checkOutput("t2_nbursts", logAddr.size() - base, 3);
    checkOutput("t2_addr0", logAddr[base], 32'h000);
    checkOutput("t2_len0", logLen[base], 255);
    checkOutput("t2_addr1", logAddr[base+1], 32'h400);
    checkOutput("t2_len1", logLen[base+1], 255);
    checkOutput("t2_addr2", logAddr[base+2], 32'h800);
    checkOutput("t2_len2", logLen[base+2], 87);
    checkOutput("t2_done_count", doneCount - d0, 1);

    // 4 KB boundary split
    base = logAddr.size();
    applyStimulus(32'hFF0, 8, 32'h0, 2, 1'b1);
    checkOutput("t3_addr0", logAddr[base], 32'hFF0);
    checkOutput("t3_len0", logLen[base], 3);
    checkOutput("t3_addr1", logAddr[base+1], 32'h1000);
    checkOutput("t3_len1", logLen[base+1], 3);
    checkOutput("t3_err", err, 0);

    // Unaligned single word
    base = logAddr.size();
    applyStimulus(32'h003, 1, 32'h0, 1, 1'b1);
    checkOutput("t4a_addr", logAddr[base], 32'h000);
    checkOutput("t4a_len", logLen[base], 0);

    // Zero-length request
    base = logAddr.size(); d0 = doneCount;
    applyStimulus(32'h040, 0, 32'h0, 1, 1'b1);
    checkOutput("t4b_done_cycle", doneCycle - accCycle, 0);
    checkOutput("t4b_done_count", doneCount - d0, 1);
    checkOutput("t4b_no_burst", logAddr.size() - base, 0);
    @(posedge clk);
    #1;
    checkOutput("t4b_ready_again", req_ready, 1);
    checkOutput("t4b_done_low", done, 0);

    // Error on the second burst only
    base = logAddr.size();
    applyStimulus(32'h000, 600, 32'h2, 2, 1'b1);
    checkOutput("t5_nbursts", logAddr.size() - base, 3);
    checkOutput("t5_err", err, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_err_held", err, 1);
    base = logAddr.size();
    applyStimulus(32'h200, 2, 32'h0, 1, 1'b1);
    checkOutput("t5_next_addr", logAddr[base], 32'h200);
    checkOutput("t5_next_err", err, 0);

    // Reset while waiting on burst 2
    base = logAddr.size(); d0 = doneCount;
    applyStimulus(32'h000, 600, 32'h0, 10, 1'b0);
    g = 0;
    while (logAddr.size() < base + 2 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("t6_reached_burst2", logAddr.size() - base, 2);
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    inXfer = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6_run", run, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_req_ready", req_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t6_no_done", doneCount - d0, 0);
    checkOutput("t6_no_more_bursts", logAddr.size() - base, 2);
    base = logAddr.size();
    applyStimulus(32'h100, 4, 32'h0, 1, 1'b1);
    checkOutput("t6_after_addr", logAddr[base], 32'h100);
    checkOutput("t6_after_len", logLen[base], 3);
    checkOutput("t6_after_run_latency", runCycle[base] - accCycle, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
